// File: rtl/riscv_pkg.sv
// Shared widths, the NOP encoding and the fetch FSM state type
// used by the instruction fetch front end.
package riscv_pkg;
  localparam int XLEN   = 32;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DRAIN
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, used for the fetch buffer and the
// request-address tag queue. DEPTH must be a power of two.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count < CNT_W'(DEPTH)) || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word-aligned requests,
// pairs returned words with their request PC and hands {pc,inst} to decode.
module inst_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              QDEPTH   = 2,
  parameter int              CNT_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              halt,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [XLEN-1:0]   if_pc,
  output logic [INST_W-1:0] if_inst
);
  fetch_state_e     state;
  logic [XLEN-1:0]  pc;
  logic [CNT_W-1:0] drop;
  logic [CNT_W-1:0] drop_next;

  logic [CNT_W-1:0]       buf_count;
  logic [CNT_W-1:0]       tag_count;
  logic [XLEN+INST_W-1:0] buf_head;
  logic [XLEN-1:0]        tag_head;
  logic [CNT_W:0]         in_use;

  logic rsp_drop;
  logic rsp_take;
  logic rsp_push;
  logic req_fire;
  logic if_pop;
  logic unused_bits;

  // The tag FIFO occupancy is the outstanding-request count.
  assign rsp_drop = imem_rsp_valid && (drop != '0);
  assign rsp_take = imem_rsp_valid && (drop == '0) && (tag_count != '0);
  assign rsp_push = rsp_take && !redirect_valid;

  assign in_use         = {1'b0, buf_count} + {1'b0, tag_count};
  assign imem_req_valid = (state == ST_FETCH) && !halt && !redirect_valid &&
                          (in_use < (CNT_W+1)'(QDEPTH));
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign imem_addr      = pc;

  assign if_valid = (buf_count != '0);
  assign if_pop   = if_valid && if_ready;
  assign if_pc    = if_valid ? buf_head[XLEN+INST_W-1:INST_W] : '0;
  assign if_inst  = if_valid ? buf_head[INST_W-1:0] : INST_NOP;

  assign unused_bits = ^redirect_pc[1:0];

  // A response landing in the redirect cycle is already stale, so it is
  // removed from the outstanding total rather than added to drop.
  always_comb begin
    drop_next = drop - CNT_W'(rsp_drop);
    if (redirect_valid) drop_next = drop_next + tag_count - CNT_W'(rsp_take);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BOOT;
      pc    <= {RESET_PC[XLEN-1:2], 2'b00};
      drop  <= '0;
    end else begin
      drop <= drop_next;
      case (state)
        ST_BOOT:  state <= ST_FETCH;
        ST_FETCH: if (redirect_valid && (drop_next != '0)) state <= ST_DRAIN;
        ST_DRAIN: if (drop_next == '0) state <= ST_FETCH;
        default:  state <= ST_BOOT;
      endcase
      if (redirect_valid)  pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (req_fire)   pc <= pc + 32'd4;
    end
  end

  fetch_fifo #(
    .WIDTH(XLEN + INST_W),
    .DEPTH(QDEPTH),
    .CNT_W(CNT_W)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (rsp_push),
    .push_data({tag_head, imem_rsp_data}),
    .pop      (if_pop),
    .head     (buf_head),
    .count    (buf_count)
  );

  fetch_fifo #(
    .WIDTH(XLEN),
    .DEPTH(QDEPTH),
    .CNT_W(CNT_W)
  ) u_tag (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (req_fire),
    .push_data(pc),
    .pop      (rsp_push),
    .head     (tag_head),
    .count    (tag_count)
  );
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: queue-based reference model,
// in-order memory model with programmable latency, directed scenarios.
module tb_inst_fetch_unit;
  import riscv_pkg::*;

  localparam int          QD  = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  inst_fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .if_valid(if_valid),
    .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  // reference model state
  logic [31:0] m_pc;
  int          m_drop;
  bit          m_booted;
  logic [63:0] m_buf[$];
  logic [31:0] m_infl[$];
  // memory model and observations
  mreq_t       mem_q[$];
  int          mem_lat = 1;
  int          cyc = 0;
  logic [63:0] popped[$];
  int          acc_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout %s @cyc %0d", name, cyc);
  endtask

  // One clock: drive memory response, compare against the model, then
  // advance model and memory on the rising edge.
  task automatic step();
    bit          e_req, e_ifv, s_rst, s_redir, s_halt, s_ifr, s_rdy, s_rspv, s_dut_req;
    logic [31:0] e_ifpc, e_ifinst, s_data, s_rpc, s_addr;
    imem_rsp_valid = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_data  = imem_rsp_valid ? word_of(mem_q[0].addr) : 32'hDEAD_BEEF;
    #1;
    e_req    = m_booted && (m_drop == 0) && !halt && !redirect_valid &&
               (m_buf.size() + m_infl.size() < QD);
    e_ifv    = m_buf.size() != 0;
    e_ifpc   = e_ifv ? m_buf[0][63:32] : 32'h0;
    e_ifinst = e_ifv ? m_buf[0][31:0] : 32'h0000_0013;
    chk("req_valid", 32'(imem_req_valid), 32'(e_req));
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", 32'(if_valid), 32'(e_ifv));
    chk("if_pc", if_pc, e_ifpc);
    chk("if_inst", if_inst, e_ifinst);
    s_rst = reset; s_redir = redirect_valid; s_halt = halt; s_ifr = if_ready;
    s_rdy = imem_req_ready; s_rspv = imem_rsp_valid; s_data = imem_rsp_data;
    s_rpc = redirect_pc; s_dut_req = imem_req_valid; s_addr = imem_addr;
    @(posedge clk);
    if (s_rspv) void'(mem_q.pop_front());
    if (s_dut_req && s_rdy) mem_q.push_back('{addr: s_addr, due: cyc + mem_lat});
    if (s_rst) begin
      m_pc = RPC; m_drop = 0; m_booted = 0;
      m_buf.delete(); m_infl.delete();
    end else begin
      if (e_ifv && s_ifr) popped.push_back(m_buf.pop_front());
      if (s_rspv) begin
        if (m_drop > 0) m_drop--;
        else if (m_infl.size() > 0) begin
          if (s_redir) void'(m_infl.pop_front());
          else m_buf.push_back({m_infl.pop_front(), s_data});
        end
      end
      if (e_req && s_rdy) begin
        m_infl.push_back(m_pc);
        m_pc = m_pc + 32'd4;
        acc_cnt++;
      end
      if (s_redir) begin
        m_drop += m_infl.size();
        m_infl.delete();
        m_buf.delete();
        m_pc = {s_rpc[31:2], 2'b00};
      end
      m_booted = 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Stop requesting and let all traffic settle.
  task automatic drain();
    int n;
    halt = 1'b1; if_ready = 1'b1;
    for (n = 0; n < 40; n++) begin
      if (mem_q.size() == 0 && m_buf.size() == 0 && m_drop == 0) break;
      step();
    end
    if (n == 40) timeout("drain");
    popped.delete();
  endtask

  task automatic wait_infl(input int k, input string name);
    int n;
    for (n = 0; n < 30; n++) begin
      if (m_infl.size() == k) break;
      step();
    end
    if (n == 30) timeout(name);
  endtask

  task automatic wait_pop(input string name);
    int n;
    for (n = 0; n < 40; n++) begin
      if (popped.size() > 0) break;
      step();
    end
    if (n == 40) timeout(name);
  endtask

  initial begin
    logic [31:0] held;
    int n;
    reset = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = '0; halt = 1'b0; if_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    m_pc = RPC; m_drop = 0; m_booted = 0;
    @(posedge clk);
    @(negedge clk);
    step();
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0000_0013);

    // 1: streaming from reset with 1-cycle memory
    reset = 1'b0;
    repeat (24) step();
    chk("t1_pops", 32'(popped.size() >= 8), 32'h1);
    chk("t1_pc0", popped[0][63:32], 32'h0000_0000);
    chk("t1_inst0", popped[0][31:0], 32'h5A5A_0000);
    chk("t1_pc1", popped[1][63:32], 32'h0000_0004);
    chk("t1_inst3", popped[3][31:0], 32'h5A5A_000C);
    for (int i = 0; i < popped.size(); i++)
      chk("t1_order", popped[i][63:32], 32'(4 * i));

    // 2: decode stalls; issue stops at QDEPTH
    drain();
    held = m_pc;
    halt = 1'b0; if_ready = 1'b0; acc_cnt = 0;
    repeat (5) step();
    chk("t2_accepts", 32'(acc_cnt), 32'd2);
    chk("t2_req_off", 32'(imem_req_valid), 32'h0);
    if_ready = 1'b1;
    repeat (10) step();
    chk("t2_first_pc", popped[0][63:32], held);
    for (int i = 1; i < popped.size(); i++)
      chk("t2_order", popped[i][63:32], popped[i-1][63:32] + 32'd4);

    // 3: redirect with two requests outstanding
    drain();
    mem_lat = 4; halt = 1'b0;
    wait_infl(2, "t3_infl");
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t3_addr", imem_addr, 32'h0000_0100);
    chk("t3_req_drain", 32'(imem_req_valid), 32'h0);
    wait_pop("t3_pop");
    chk("t3_pc", popped[0][63:32], 32'h0000_0100);
    chk("t3_inst", popped[0][31:0], 32'h5A5A_0100);

    // 4: redirect in the same cycle as a returning response
    drain();
    mem_lat = 2; halt = 1'b0;
    for (n = 0; n < 30; n++) begin
      if (m_infl.size() == 2 && mem_q.size() > 0 && mem_q[0].due <= cyc) break;
      step();
    end
    if (n == 30) timeout("t4_align");
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t4_req_drain", 32'(imem_req_valid), 32'h0);
    wait_pop("t4_pop");
    chk("t4_pc", popped[0][63:32], 32'h0000_0200);
    chk("t4_inst", popped[0][31:0], 32'h5A5A_0200);

    // 5: PC wrap and halt
    drain();
    mem_lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    halt = 1'b0;
    step();
    #1;
    chk("t5_addr_wrap", imem_addr, 32'h0000_0000);
    halt = 1'b1;
    held = imem_addr;
    repeat (5) step();
    #1;
    chk("t5_halt_req", 32'(imem_req_valid), 32'h0);
    chk("t5_halt_pc", imem_addr, held);
    chk("t5_drained_pc", popped[0][63:32], 32'hFFFF_FFFC);
    chk("t5_drained_inst", popped[0][31:0], 32'hA5A5_FFFC);

    // 6: reset with requests outstanding; late responses must be ignored
    drain();
    mem_lat = 3; halt = 1'b0;
    wait_infl(2, "t6_infl");
    reset = 1'b1;
    step();
    reset = 1'b0; halt = 1'b1;
    #1;
    chk("t6_rst_req", 32'(imem_req_valid), 32'h0);
    chk("t6_rst_addr", imem_addr, RPC);
    chk("t6_rst_ifv", 32'(if_valid), 32'h0);
    chk("t6_rst_inst", if_inst, 32'h0000_0013);
    for (n = 0; n < 20; n++) begin
      if (mem_q.size() == 0) break;
      step();
    end
    if (n == 20) timeout("t6_late");
    step();
    #1;
    chk("t6_late_ignored", 32'(if_valid), 32'h0);
    popped.delete();
    mem_lat = 1; halt = 1'b0;
    wait_pop("t6_pop");
    chk("t6_restart_pc", popped[0][63:32], RPC);
    chk("t6_restart_inst", popped[0][31:0], 32'h5A5A_0000);
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "global timeout");
  end
endmodule
